// File: rtl/am386sx_pkg.sv
// Shared definitions for the Am386SX bus-cycle responder.
// Holds the {M/IO#,D/C#,W/R#} cycle codes, the FSM state encoding and the CLK2 phase values.
// Pure declarations; no logic and no ports.
package am386sx_pkg;

    // Bus-cycle definition codes as presented on {M/IO#, D/C#, W/R#}
    localparam logic [2:0] CYC_INTA  = 3'b000;
    localparam logic [2:0] CYC_IORD  = 3'b010;
    localparam logic [2:0] CYC_IOWR  = 3'b011;
    localparam logic [2:0] CYC_HALT  = 3'b101;
    localparam logic [2:0] CYC_MEMRD = 3'b110;
    localparam logic [2:0] CYC_MEMWR = 3'b111;

    // Value of the phase output during each half of a bus state
    localparam logic PH1 = 1'b0;
    localparam logic PH2 = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T2,
        ST_REQ,
        ST_RSP,
        ST_WS,
        ST_RDY
    } bus_state_t;

    // Halt/shutdown and interrupt-acknowledge are answered without the backend
    function automatic logic cyc_is_local(input logic [2:0] code);
        return (code == CYC_HALT) || (code == CYC_INTA);
    endfunction

endpackage

// File: rtl/am386sx_reset_gen.sv
// CPU reset sequencer and CLK2 phase tracker.
// Ports: clk/reset in; cpu_reset (386 RESET pin) and phase (0 = phase 1, 1 = phase 2) out.
// cpu_reset is held RESET_CLKS clocks after reset falls, then drops on the edge that sets phase=1.
module am386sx_reset_gen
    import am386sx_pkg::*;
#(
    parameter int RESET_CLKS = 32
) (
    input  logic clk,
    input  logic reset,
    output logic cpu_reset,
    output logic phase
);

    localparam int CW = $clog2(RESET_CLKS + 1);
    localparam logic [CW-1:0] LAST = CW'(RESET_CLKS - 1);

    logic [CW-1:0] r_cnt;
    logic          r_cpu_reset;
    logic          r_phase;

    // The 386 samples the falling edge of RESET to pick its internal phase, so the
    // first CLK2 after cpu_reset falls must be seen by the CPU as its phase 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_cpu_reset <= 1'b1;
            r_phase     <= PH1;
        end else if (r_cpu_reset) begin
            if (r_cnt == LAST) begin
                r_cpu_reset <= 1'b0;
                r_phase     <= PH2;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end else begin
            r_phase <= ~r_phase;
        end
    end

    assign cpu_reset = r_cpu_reset;
    assign phase     = r_phase;

endmodule

// File: rtl/am386sx_bus_ctl.sv
// Am386SX bus-cycle responder: latches ADS#-qualified cycles, forwards memory/IO to a valid/ready backend.
// Ports: CPU pins (ADS#, status, A[23:1], D, READY#, NA#, RESET), backend req_*/rsp_*, phase, status_led.
// Every cycle ends with one bus state of READY#; halt and INTA are answered locally; backend silence times out.
module am386sx_bus_ctl
    import am386sx_pkg::*;
#(
    parameter int         RESET_CLKS  = 32,
    parameter int         WAIT_STATES = 0,
    parameter int         TIMEOUT_BS  = 15,
    parameter logic [7:0] INTA_VEC    = 8'h08
) (
    input  logic        clk,
    input  logic        reset,
    output logic        cpu_reset,
    input  logic        cpu_ads_n,
    input  logic        cpu_mio,
    input  logic        cpu_dc,
    input  logic        cpu_wr,
    input  logic        cpu_bhe_n,
    input  logic        cpu_ble_n,
    input  logic [22:0] cpu_addr,
    input  logic [15:0] cpu_data_i,
    output logic [15:0] cpu_data_o,
    output logic        cpu_data_oe,
    output logic        cpu_ready_n,
    output logic        cpu_na_n,
    output logic        phase,
    output logic        req_valid,
    input  logic        req_ready,
    output logic        req_io,
    output logic        req_wr,
    output logic [23:0] req_addr,
    output logic [1:0]  req_be,
    output logic [15:0] req_wdata,
    input  logic        rsp_valid,
    input  logic [15:0] rsp_rdata,
    output logic [7:0]  status_led
);

    localparam logic [2:0] WS_N   = 3'(WAIT_STATES);
    localparam logic [2:0] WS_M1  = WS_N - 3'd1;
    localparam logic [7:0] TO_BS  = 8'(TIMEOUT_BS);

    bus_state_t  r_state;
    logic [2:0]  r_code;
    logic [23:0] r_req_addr;
    logic [1:0]  r_req_be;
    logic        r_req_io;
    logic        r_req_wr;
    logic [15:0] r_req_wdata;
    logic        r_req_valid;
    logic        r_ready_n;
    logic [15:0] r_data_o;
    logic        r_data_oe;
    logic [7:0]  r_bs_cnt;
    logic [2:0]  r_ws_cnt;
    logic        r_inta_2nd;
    logic [3:0]  r_led;

    logic w_phase;
    logic w_mid_edge;   // edge inside a bus state: READY# changes here so it is stable at sampling
    logic w_end_edge;   // edge closing a bus state: the CPU samples ADS#/READY# here
    logic w_rsp_take;

    am386sx_reset_gen #(
        .RESET_CLKS (RESET_CLKS)
    ) u_reset_gen (
        .clk       (clk),
        .reset     (reset),
        .cpu_reset (cpu_reset),
        .phase     (w_phase)
    );

    assign w_mid_edge = (w_phase == PH1);
    assign w_end_edge = (w_phase == PH2);
    // A response only counts once the request has been (or is being) accepted
    assign w_rsp_take = rsp_valid &&
                        (((r_state == ST_REQ) && req_ready) || (r_state == ST_RSP));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_code      <= '0;
            r_req_addr  <= '0;
            r_req_be    <= '0;
            r_req_io    <= 1'b0;
            r_req_wr    <= 1'b0;
            r_req_wdata <= '0;
            r_req_valid <= 1'b0;
            r_ready_n   <= 1'b1;
            r_data_o    <= '0;
            r_data_oe   <= 1'b0;
            r_bs_cnt    <= '0;
            r_ws_cnt    <= '0;
            r_inta_2nd  <= 1'b0;
            r_led       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_end_edge && !cpu_ads_n) begin
                        r_code     <= {cpu_mio, cpu_dc, cpu_wr};
                        r_req_addr <= {cpu_addr, 1'b0};
                        r_req_be   <= {~cpu_bhe_n, ~cpu_ble_n};
                        r_req_io   <= ~cpu_mio;
                        r_req_wr   <= cpu_wr;
                        r_state    <= ST_T2;
                    end
                end

                ST_T2: begin
                    if (cyc_is_local(r_code)) begin
                        // Local cycles drive READY# within the first T2
                        if (w_mid_edge) begin
                            r_state   <= ST_RDY;
                            r_ready_n <= 1'b0;
                            r_data_oe <= ~r_req_wr;
                            r_data_o  <= (r_code == CYC_INTA && r_inta_2nd) ?
                                         {8'h00, INTA_VEC} : 16'h0000;
                            if (r_code == CYC_INTA)
                                r_inta_2nd <= ~r_inta_2nd;
                        end
                    end else if (w_end_edge) begin
                        // Write data is valid on the pins by the end of the first T2
                        r_req_wdata <= cpu_data_i;
                        r_req_valid <= 1'b1;
                        r_bs_cnt    <= '0;
                        r_state     <= ST_REQ;
                    end
                end

                ST_REQ, ST_RSP: begin
                    if (w_rsp_take) begin
                        r_req_valid <= 1'b0;
                        r_data_o    <= rsp_rdata;
                        if (w_mid_edge && WS_N == 3'd0) begin
                            r_state   <= ST_RDY;
                            r_ready_n <= 1'b0;
                            r_data_oe <= ~r_req_wr;
                        end else begin
                            // Count remaining mid-state edges before READY# may assert
                            r_state  <= ST_WS;
                            r_ws_cnt <= w_mid_edge ? WS_M1 : WS_N;
                        end
                    end else if (w_mid_edge && r_bs_cnt >= TO_BS) begin
                        r_req_valid <= 1'b0;
                        r_data_o    <= 16'hFFFF;
                        r_ready_n   <= 1'b0;
                        r_data_oe   <= ~r_req_wr;
                        r_led[3]    <= 1'b1;
                        r_state     <= ST_RDY;
                    end else begin
                        if (r_state == ST_REQ && req_ready) begin
                            r_req_valid <= 1'b0;
                            r_state     <= ST_RSP;
                        end
                        if (w_end_edge)
                            r_bs_cnt <= r_bs_cnt + 8'd1;
                    end
                end

                ST_WS: begin
                    if (w_mid_edge) begin
                        if (r_ws_cnt == 3'd0) begin
                            r_state   <= ST_RDY;
                            r_ready_n <= 1'b0;
                            r_data_oe <= ~r_req_wr;
                        end else begin
                            r_ws_cnt <= r_ws_cnt - 3'd1;
                        end
                    end
                end

                ST_RDY: begin
                    // Entered on a mid-state edge, so the next one is exactly 2 clk later
                    if (w_mid_edge) begin
                        r_state   <= ST_IDLE;
                        r_ready_n <= 1'b1;
                        r_data_oe <= 1'b0;
                        r_led[0]  <= ~r_led[0];
                        r_led[1]  <= r_req_wr;
                        r_led[2]  <= r_req_io;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign phase       = w_phase;
    assign cpu_na_n    = 1'b1;
    assign cpu_ready_n = r_ready_n;
    assign cpu_data_o  = r_data_o;
    assign cpu_data_oe = r_data_oe;
    assign req_valid   = r_req_valid;
    assign req_io      = r_req_io;
    assign req_wr      = r_req_wr;
    assign req_addr    = r_req_addr;
    assign req_be      = r_req_be;
    assign req_wdata   = r_req_wdata;
    assign status_led  = {4'b0000, r_led};

endmodule

// File: tb/tb_am386sx_bus_ctl.sv
// Self-checking bench for am386sx_bus_ctl: table of zero-wait backend cycles plus directed sequences.
// Two instances: A (WAIT_STATES=0) and B (WAIT_STATES=2); sel_b routes ADS#/backend strobes and observation.
// Inputs are driven and outputs sampled 1 time unit after each rising clk edge.
module tb_am386sx_bus_ctl;
    import am386sx_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ads_n, mio, dc, wr, bhe_n, ble_n;
    logic [22:0] addr;
    logic [15:0] data_i;
    logic        sel_b, req_rdy, rsp_vld;
    logic [15:0] rdata;

    logic        a_cpu_reset, a_oe, a_ready_n, a_na_n, a_phase, a_req_valid, a_req_io, a_req_wr;
    logic [15:0] a_data_o, a_req_wdata;
    logic [23:0] a_req_addr;
    logic [1:0]  a_req_be;
    logic [7:0]  a_led;
    logic        b_cpu_reset, b_oe, b_ready_n, b_na_n, b_phase, b_req_valid, b_req_io, b_req_wr;
    logic [15:0] b_data_o, b_req_wdata;
    logic [23:0] b_req_addr;
    logic [1:0]  b_req_be;
    logic [7:0]  b_led;

    wire        ads_a   = sel_b ? 1'b1 : ads_n;
    wire        ads_b   = sel_b ? ads_n : 1'b1;
    wire        rdy_a   = sel_b ? 1'b0 : req_rdy;
    wire        rdy_b   = sel_b ? req_rdy : 1'b0;
    wire        rsp_a   = sel_b ? 1'b0 : rsp_vld;
    wire        rsp_b   = sel_b ? rsp_vld : 1'b0;

    wire        o_cpu_reset = sel_b ? b_cpu_reset : a_cpu_reset;
    wire        o_oe        = sel_b ? b_oe        : a_oe;
    wire        o_ready_n   = sel_b ? b_ready_n   : a_ready_n;
    wire        o_na_n      = sel_b ? b_na_n      : a_na_n;
    wire        o_phase     = sel_b ? b_phase     : a_phase;
    wire        o_req_valid = sel_b ? b_req_valid : a_req_valid;
    wire        o_req_io    = sel_b ? b_req_io    : a_req_io;
    wire        o_req_wr    = sel_b ? b_req_wr    : a_req_wr;
    wire [15:0] o_data_o    = sel_b ? b_data_o    : a_data_o;
    wire [15:0] o_req_wdata = sel_b ? b_req_wdata : a_req_wdata;
    wire [23:0] o_req_addr  = sel_b ? b_req_addr  : a_req_addr;
    wire [1:0]  o_req_be    = sel_b ? b_req_be    : a_req_be;
    wire [7:0]  o_led       = sel_b ? b_led       : a_led;

    am386sx_bus_ctl #(.RESET_CLKS(32), .WAIT_STATES(0), .TIMEOUT_BS(15), .INTA_VEC(8'h08)) dut_a (
        .clk(clk), .reset(reset), .cpu_reset(a_cpu_reset), .cpu_ads_n(ads_a),
        .cpu_mio(mio), .cpu_dc(dc), .cpu_wr(wr), .cpu_bhe_n(bhe_n), .cpu_ble_n(ble_n),
        .cpu_addr(addr), .cpu_data_i(data_i), .cpu_data_o(a_data_o), .cpu_data_oe(a_oe),
        .cpu_ready_n(a_ready_n), .cpu_na_n(a_na_n), .phase(a_phase),
        .req_valid(a_req_valid), .req_ready(rdy_a), .req_io(a_req_io), .req_wr(a_req_wr),
        .req_addr(a_req_addr), .req_be(a_req_be), .req_wdata(a_req_wdata),
        .rsp_valid(rsp_a), .rsp_rdata(rdata), .status_led(a_led));

    am386sx_bus_ctl #(.RESET_CLKS(32), .WAIT_STATES(2), .TIMEOUT_BS(15), .INTA_VEC(8'h08)) dut_b (
        .clk(clk), .reset(reset), .cpu_reset(b_cpu_reset), .cpu_ads_n(ads_b),
        .cpu_mio(mio), .cpu_dc(dc), .cpu_wr(wr), .cpu_bhe_n(bhe_n), .cpu_ble_n(ble_n),
        .cpu_addr(addr), .cpu_data_i(data_i), .cpu_data_o(b_data_o), .cpu_data_oe(b_oe),
        .cpu_ready_n(b_ready_n), .cpu_na_n(b_na_n), .phase(b_phase),
        .req_valid(b_req_valid), .req_ready(rdy_b), .req_io(b_req_io), .req_wr(b_req_wr),
        .req_addr(b_req_addr), .req_be(b_req_be), .req_wdata(b_req_wdata),
        .rsp_valid(rsp_b), .rsp_rdata(rdata), .status_led(b_led));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  code;
        logic [23:0] addr;
        logic [1:0]  be;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        exp_io;
        logic        exp_wr;
        logic        exp_oe;
        logic [15:0] exp_do;
    } vec_t;

    vec_t       vt[5];
    logic [7:0] led_a_exp;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Leave the bench at a point where the next rising edge is an ADS# sampling edge
    task automatic align();
        for (int i = 0; i < 3; i++)
            if (o_phase !== 1'b1) tick();
        chk("align_phase", o_phase, 1'b1);
    endtask

    // Present one T1 with ADS# low; returns just after the sampling edge (E1)
    task automatic issue(input logic [2:0] code, input logic [23:0] a,
                         input logic [1:0] be, input logic [15:0] d);
        align();
        {mio, dc, wr} = code;
        addr   = a[23:1];
        bhe_n  = ~be[1];
        ble_n  = ~be[0];
        data_i = d;
        ads_n  = 1'b0;
        tick();
        ads_n  = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{CYC_MEMRD, 24'h0F0000, 2'b11, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 1'b1, 16'hBEEF};
        vt[1] = '{CYC_MEMWR, 24'h123456, 2'b01, 16'h5A5A, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000};
        vt[2] = '{CYC_IORD,  24'h0003F8, 2'b10, 16'h0000, 16'h00C3, 1'b1, 1'b0, 1'b1, 16'h00C3};
        vt[3] = '{3'b100,    24'hFFFFFE, 2'b11, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b1, 16'h1234};
        vt[4] = '{CYC_IOWR,  24'h0000FE, 2'b11, 16'h7E81, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000};
        led_a_exp = 8'h00;

        reset = 1'b1; ads_n = 1'b1; {mio, dc, wr} = 3'b110; bhe_n = 1'b1; ble_n = 1'b1;
        addr = '0; data_i = '0; sel_b = 1'b0; req_rdy = 1'b0; rsp_vld = 1'b0; rdata = '0;

        // Reset values
        #2;
        chk("rst_cpu_reset", o_cpu_reset, 1'b1);
        chk("rst_phase", o_phase, 1'b0);
        chk("rst_ready_n", o_ready_n, 1'b1);
        chk("rst_oe", o_oe, 1'b0);
        chk("rst_req_valid", o_req_valid, 1'b0);
        chk("rst_led", o_led, 8'h00);
        chk("rst_req_addr", o_req_addr, 24'h0);
        chk("rst_data_o", o_data_o, 16'h0);
        chk("na_n", o_na_n, 1'b1);

        // Reset release: cpu_reset falls on the 32nd clk with phase=1
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 34; k++) begin
            tick();
            if (k == 1 || k == 31) begin
                chk($sformatf("seq%0d_cpu_reset", k), o_cpu_reset, 1'b1);
                chk($sformatf("seq%0d_phase", k), o_phase, 1'b0);
            end
            if (k == 32) begin
                chk("seq32_cpu_reset", o_cpu_reset, 1'b0);
                chk("seq32_phase", o_phase, 1'b1);
            end
            if (k == 33) chk("seq33_phase", o_phase, 1'b0);
            if (k == 34) chk("seq34_phase", o_phase, 1'b1);
        end

        // Zero-wait backend cycles, ready and response on the same edge
        for (int i = 0; i < 5; i++) begin
            issue(vt[i].code, vt[i].addr, vt[i].be, vt[i].wdata);
            tick();                                         // E1+1
            chk($sformatf("v%0d_t2_valid", i), o_req_valid, 1'b0);
            tick();                                         // E1+2
            chk($sformatf("v%0d_valid", i), o_req_valid, 1'b1);
            chk($sformatf("v%0d_io", i), o_req_io, vt[i].exp_io);
            chk($sformatf("v%0d_wr", i), o_req_wr, vt[i].exp_wr);
            chk($sformatf("v%0d_addr", i), o_req_addr, vt[i].addr);
            chk($sformatf("v%0d_be", i), o_req_be, vt[i].be);
            if (vt[i].exp_wr) chk($sformatf("v%0d_wdata", i), o_req_wdata, vt[i].wdata);
            chk($sformatf("v%0d_rdy_early", i), o_ready_n, 1'b1);
            req_rdy = 1'b1; rsp_vld = 1'b1; rdata = vt[i].rdata;
            tick();                                         // E1+3: READY# asserted
            req_rdy = 1'b0; rsp_vld = 1'b0; rdata = 16'hDEAD;
            chk($sformatf("v%0d_ready_lo0", i), o_ready_n, 1'b0);
            chk($sformatf("v%0d_valid_drop", i), o_req_valid, 1'b0);
            chk($sformatf("v%0d_oe", i), o_oe, vt[i].exp_oe);
            if (vt[i].exp_oe) chk($sformatf("v%0d_data", i), o_data_o, vt[i].exp_do);
            tick();                                         // E1+4
            chk($sformatf("v%0d_ready_lo1", i), o_ready_n, 1'b0);
            if (vt[i].exp_oe) chk($sformatf("v%0d_data_hold", i), o_data_o, vt[i].exp_do);
            tick();                                         // E1+5: back to idle
            led_a_exp[0] = ~led_a_exp[0];
            led_a_exp[1] = vt[i].exp_wr;
            led_a_exp[2] = vt[i].exp_io;
            chk($sformatf("v%0d_ready_hi", i), o_ready_n, 1'b1);
            chk($sformatf("v%0d_oe_off", i), o_oe, 1'b0);
            chk($sformatf("v%0d_led", i), o_led, led_a_exp);
        end

        // IO write with two wait states on instance B; a stray ADS# mid-cycle is ignored
        sel_b = 1'b1;
        issue(CYC_IOWR, 24'h000080, 2'b11, 16'h00A5);
        tick(); tick();                                     // E1+2
        chk("ws_valid", o_req_valid, 1'b1);
        chk("ws_io", o_req_io, 1'b1);
        chk("ws_addr", o_req_addr, 24'h000080);
        chk("ws_wdata", o_req_wdata, 16'h00A5);
        data_i = 16'h1234;
        tick();                                             // E1+3: still unaccepted
        chk("ws_valid_hold", o_req_valid, 1'b1);
        chk("ws_wdata_hold", o_req_wdata, 16'h00A5);
        req_rdy = 1'b1;
        tick();                                             // E1+4: accepted
        req_rdy = 1'b0;
        chk("ws_valid_drop", o_req_valid, 1'b0);
        rsp_vld = 1'b1;
        tick();                                             // E1+5: response taken
        rsp_vld = 1'b0;
        {mio, dc, wr} = CYC_MEMRD; addr = 23'h078787; ads_n = 1'b0;
        tick();                                             // E1+6: stray ADS# sampled
        ads_n = 1'b1;
        chk("ws_ready_e6", o_ready_n, 1'b1);
        tick(); tick();                                     // E1+8
        chk("ws_ready_e8", o_ready_n, 1'b1);
        tick();                                             // E1+9
        chk("ws_ready_e9", o_ready_n, 1'b0);
        chk("ws_oe_write", o_oe, 1'b0);
        tick();
        chk("ws_ready_e10", o_ready_n, 1'b0);
        tick();
        chk("ws_ready_e11", o_ready_n, 1'b1);
        chk("ws_led", o_led, 8'h07);
        tick(); tick();
        chk("ws_stray_valid", o_req_valid, 1'b0);
        chk("ws_stray_addr", o_req_addr, 24'h000080);
        sel_b = 1'b0;

        // Backend never answers: timeout after 15 bus states
        issue(CYC_MEMRD, 24'h000100, 2'b11, 16'h0000);
        for (int k = 1; k <= 32; k++) tick();
        chk("to_ready_e32", o_ready_n, 1'b1);
        chk("to_valid_e32", o_req_valid, 1'b1);
        tick();                                             // E1+33
        chk("to_ready_e33", o_ready_n, 1'b0);
        chk("to_data", o_data_o, 16'hFFFF);
        chk("to_oe", o_oe, 1'b1);
        chk("to_valid_drop", o_req_valid, 1'b0);
        chk("to_led3", o_led[3], 1'b1);
        tick(); tick();                                     // E1+35
        led_a_exp[0] = ~led_a_exp[0];
        led_a_exp[1] = 1'b0;
        led_a_exp[2] = 1'b0;
        led_a_exp[3] = 1'b1;
        chk("to_ready_end", o_ready_n, 1'b1);
        chk("to_led", o_led, led_a_exp);
        rsp_vld = 1'b1; rdata = 16'h5555;
        tick();
        rsp_vld = 1'b0;
        tick();
        chk("to_stray_ready", o_ready_n, 1'b1);
        chk("to_stray_oe", o_oe, 1'b0);

        // Halt: local, no request, READY# in the first T2
        issue(CYC_HALT, 24'h000002, 2'b11, 16'h0000);
        tick();                                             // E1+1
        chk("halt_ready", o_ready_n, 1'b0);
        chk("halt_oe", o_oe, 1'b0);
        chk("halt_valid", o_req_valid, 1'b0);
        tick();
        chk("halt_ready_hold", o_ready_n, 1'b0);
        chk("halt_valid2", o_req_valid, 1'b0);
        tick();
        led_a_exp[0] = ~led_a_exp[0];
        led_a_exp[1] = 1'b1;
        led_a_exp[2] = 1'b0;
        chk("halt_ready_end", o_ready_n, 1'b1);
        chk("halt_led_sticky", o_led, led_a_exp);

        // Two INTA cycles: vector only on the second
        for (int n = 0; n < 2; n++) begin
            issue(CYC_INTA, 24'h000000, 2'b11, 16'h0000);
            tick();
            chk($sformatf("inta%0d_ready", n), o_ready_n, 1'b0);
            chk($sformatf("inta%0d_oe", n), o_oe, 1'b1);
            chk($sformatf("inta%0d_data", n), o_data_o, (n == 1) ? 16'h0008 : 16'h0000);
            chk($sformatf("inta%0d_valid", n), o_req_valid, 1'b0);
            tick();
            chk($sformatf("inta%0d_data_hold", n), o_data_o, (n == 1) ? 16'h0008 : 16'h0000);
            tick();
            led_a_exp[0] = ~led_a_exp[0];
            chk($sformatf("inta%0d_ready_end", n), o_ready_n, 1'b1);
            chk($sformatf("inta%0d_led0", n), o_led[0], led_a_exp[0]);
            chk($sformatf("inta%0d_led3", n), o_led[3], 1'b1);
        end

        // Reset while waiting in RSP
        issue(CYC_MEMRD, 24'h000200, 2'b11, 16'h0000);
        tick(); tick();                                     // E1+2
        req_rdy = 1'b1;
        tick();                                             // E1+3: in RSP
        req_rdy = 1'b0;
        chk("rsp_state_valid", o_req_valid, 1'b0);
        chk("rsp_state_ready", o_ready_n, 1'b1);
        reset = 1'b1;
        #1;
        chk("mid_cpu_reset", o_cpu_reset, 1'b1);
        chk("mid_phase", o_phase, 1'b0);
        chk("mid_ready_n", o_ready_n, 1'b1);
        chk("mid_oe", o_oe, 1'b0);
        chk("mid_req_valid", o_req_valid, 1'b0);
        chk("mid_led", o_led, 8'h00);
        chk("mid_req_addr", o_req_addr, 24'h0);
        rsp_vld = 1'b1; rdata = 16'h9999;
        tick(); tick();
        rsp_vld = 1'b0;
        chk("mid_hold_ready_n", o_ready_n, 1'b1);
        chk("mid_hold_data", o_data_o, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
